axis_address_arbiter: RTL and testbench
=======================================

# axis_address_arbiter

Priority arbiter with starvation aging that shares one AXIS address command channel between `NPRT` requesters. It sits in front of the AXIS-to-AXI memory path and hands the downstream engine one command at a time, together with the index of the port that issued it. Zero-beat commands are consumed and flagged, never forwarded.

## Interface
- `NPRT`, 4: number of requesting ports (>= 2).
- `ADDR_WIDTH`, 32: width of the address and beat-count fields.
- `AGE_WIDTH`, 8: width of each per-port age counter.
- `AGE_LIMIT`, 64: age at which a waiting port is promoted to starving.
- `aclk` input 1: clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `s_avalid` input NPRT: per-port command valid.
- `s_arnw` input NPRT: per-port direction; 0 = read, 1 = write.
- `s_aaddr` input NPRT*ADDR_WIDTH: per-port address, port i at bits `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `s_abeats` input NPRT*ADDR_WIDTH: per-port beat count, same packing as `s_aaddr`.
- `s_aready` output NPRT: per-port accept, one-hot or zero.
- `m_avalid` output 1: forwarded command valid.
- `m_arnw` output 1: forwarded direction.
- `m_aaddr` output ADDR_WIDTH: forwarded address.
- `m_abeats` output ADDR_WIDTH: forwarded beat count.
- `m_aport` output clog2(NPRT): index of the port that issued the command.
- `m_aready` input 1: downstream accept.
- `zeroBeatError` output 1: sticky flag, set when a request with `s_abeats == 0` is accepted.

## Operation
- The state machine has two states.
  - IDLE: arbitrate among the ports and accept one command.
  - ISSUE: present the registered command until `m_aready`.
- Arbitration is evaluated combinationally in IDLE only:
  - A port is starving when `s_avalid[i]` is high and `age[i] >= AGE_LIMIT`.
  - If any port is starving, the winner is the lowest-index starving port.
  - Otherwise the winner is the lowest-index port with `s_avalid` high.
- `s_aready[i] = !reset && state==IDLE && any valid && winner==i`.
- Accepting a command (IDLE and a handshake) does the following:
  - Registers `s_arnw`, `s_aaddr`, `s_abeats` and the winner index into the `m_*` outputs.
  - Enters ISSUE if the beat count is non-zero.
  - If the beat count is zero, stays in IDLE, sets `zeroBeatError`, and forwards nothing.
- In ISSUE, `m_avalid` is 1 and the `m_*` payload is stable. When `m_avalid && m_aready`, the next state is IDLE.
- Age counters update every cycle in both states:
  - `age[i]` resets to 0 when port i is granted or `s_avalid[i]` is low.
  - Otherwise `age[i]` increments by 1, saturating at `2^AGE_WIDTH-1`.
- Requesters hold `s_avalid` and their payload until they see `s_aready`. The arbiter never retracts `s_aready` within a cycle.

## Timing
- Reset values:
  - State is IDLE.
  - `s_aready`, `m_avalid`, `m_arnw`, `m_aaddr`, `m_abeats`, `m_aport`, `zeroBeatError` and all `age[i]` are 0.
- Latency: an accept in cycle N drives `m_avalid` high with the payload in cycle N+1.
- Throughput: at most one command every 2 cycles. The earliest next accept is the cycle after the `m_aready` handshake.
- Backpressure: with `m_aready` low, `m_avalid` and the payload hold, and `s_aready` stays 0.
- Simultaneous requests: exactly one port is accepted per IDLE cycle; the others keep aging.
- Reset asserted in ISSUE: `m_avalid` is 0 in the next cycle. The command is dropped and not replayed.
- `zeroBeatError` clears only on reset.

## Configuration
- `RASTERIX_ARBITER_AGING_EN` defined: age counters and starvation promotion are compiled in, as described above.
- Not defined:
  - No age counters are synthesized.
  - The arbiter is strict fixed priority: lowest-index valid port wins.
  - `AGE_WIDTH` and `AGE_LIMIT` are ignored.

## Test plan
- Single request: port 2 with addr 0x1000, beats 16, `m_aready`=1.
  - `s_aready[2]` at cycle N.
  - `m_avalid`=1 at N+1 with `m_aport`=2, `m_aaddr`=0x1000, `m_abeats`=16.
  - `m_avalid`=0 at N+2.
- Contention: ports 0 and 3 valid in the same cycle → port 0 is accepted first; port 3 is accepted at the next IDLE cycle, 2 cycles later.
- Backpressure: `m_aready` held 0 for 5 cycles → `m_avalid` and the payload are unchanged for all 5 cycles, and `s_aready` is all zero until 1 cycle after `m_aready`=1.
- Starvation, with `AGE_LIMIT`=4: port 0 re-requests continuously while port 1 waits.
  - With the macro defined, port 1 is granted once its age reaches 4.
  - Without the macro, port 1 is never granted while port 0 is valid.
- Zero beats: port 1 sends beats 0 → `s_aready[1]` pulses, `m_avalid` stays 0, and `zeroBeatError`=1 until reset.
- Reset in ISSUE: `reset`=1 while `m_avalid`=1 → all outputs return to 0 the next cycle, and no command is replayed after release.

Source files
------------

// File: rtl/axis_address_arbiter_if.sv
// Command channel bundle for axis_address_arbiter: NPRT packed
// requester ports on the s_* side, one forwarded command on the m_* side.
interface axis_address_arbiter_if #(
    parameter int NPRT       = 4,
    parameter int ADDR_WIDTH = 32
) ();
    localparam int PW = $clog2(NPRT);

    logic [NPRT-1:0]            s_avalid;
    logic [NPRT-1:0]            s_arnw;
    logic [NPRT*ADDR_WIDTH-1:0] s_aaddr;
    logic [NPRT*ADDR_WIDTH-1:0] s_abeats;
    logic [NPRT-1:0]            s_aready;

    logic                  m_avalid;
    logic                  m_arnw;
    logic [ADDR_WIDTH-1:0] m_aaddr;
    logic [ADDR_WIDTH-1:0] m_abeats;
    logic [PW-1:0]         m_aport;
    logic                  m_aready;

    logic zeroBeatError;

    // Arbiter side: takes requests, issues one command downstream.
    modport slave (
        input  s_avalid, s_arnw, s_aaddr, s_abeats, m_aready,
        output s_aready, m_avalid, m_arnw, m_aaddr, m_abeats, m_aport,
        output zeroBeatError
    );

    // Environment side: requesters plus the downstream engine.
    modport master (
        output s_avalid, s_arnw, s_aaddr, s_abeats, m_aready,
        input  s_aready, m_avalid, m_arnw, m_aaddr, m_abeats, m_aport,
        input  zeroBeatError
    );
endinterface

// File: rtl/axis_address_arbiter.sv
// Priority arbiter sharing one address command channel among NPRT ports.
// Define RASTERIX_ARBITER_AGING_EN to add per-port starvation aging.
module axis_address_arbiter #(
    parameter int NPRT       = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int AGE_WIDTH  = 8,
    parameter int AGE_LIMIT  = 64
) (
    input logic aclk,
    input logic reset,
    axis_address_arbiter_if.slave bus
);
    localparam int PW = $clog2(NPRT);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t state, state_nx;

    logic [NPRT-1:0]       cand;
    logic [NPRT-1:0]       grant;
    logic                  any_valid;
    logic                  accept;
    logic                  zero_beats;
    logic [PW-1:0]         winner;
    logic                  sel_rnw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] sel_beats;

    logic                  rnw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] beats_q;
    logic [PW-1:0]         port_q;
    logic                  zero_err_q;

    assign any_valid = |bus.s_avalid;

`ifdef RASTERIX_ARBITER_AGING_EN
    logic [AGE_WIDTH-1:0] age [NPRT];
    logic [NPRT-1:0]      starving;

    always_comb begin
        starving = '0;
        for (int i = 0; i < NPRT; i++) begin
            starving[i] = bus.s_avalid[i] &&
                          (age[i] >= AGE_WIDTH'(AGE_LIMIT));
        end
        cand = (|starving) ? starving : bus.s_avalid;
    end

    // Age clears on grant or idle port and saturates instead of wrapping.
    always_ff @(posedge aclk) begin
        for (int i = 0; i < NPRT; i++) begin
            if (reset || grant[i] || !bus.s_avalid[i]) begin
                age[i] <= '0;
            end else if (age[i] != '1) begin
                age[i] <= age[i] + 1'b1;
            end
        end
    end
`else
    assign cand = bus.s_avalid;
`endif

    always_comb begin
        winner = '0;
        for (int i = NPRT - 1; i >= 0; i--) begin
            if (cand[i]) begin
                winner = PW'(i);
            end
        end
    end

    always_comb begin
        sel_rnw   = 1'b0;
        sel_addr  = '0;
        sel_beats = '0;
        for (int i = 0; i < NPRT; i++) begin
            if (winner == PW'(i)) begin
                sel_rnw   = bus.s_arnw[i];
                sel_addr  = bus.s_aaddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_beats = bus.s_abeats[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (!reset && state == IDLE && any_valid) begin
            grant[winner] = 1'b1;
        end
    end

    assign accept     = |grant;
    assign zero_beats = (sel_beats == '0);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && !zero_beats) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_aready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Payload is captured even for zero-beat commands; only m_avalid gates it.
    always_ff @(posedge aclk) begin
        if (reset) begin
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            beats_q    <= '0;
            port_q     <= '0;
            zero_err_q <= 1'b0;
        end else if (accept) begin
            rnw_q   <= sel_rnw;
            addr_q  <= sel_addr;
            beats_q <= sel_beats;
            port_q  <= winner;
            if (zero_beats) begin
                zero_err_q <= 1'b1;
            end
        end
    end

    assign bus.s_aready      = grant;
    assign bus.m_avalid      = (state == ISSUE);
    assign bus.m_arnw        = rnw_q;
    assign bus.m_aaddr       = addr_q;
    assign bus.m_abeats      = beats_q;
    assign bus.m_aport       = port_q;
    assign bus.zeroBeatError = zero_err_q;
endmodule

// File: tb/tb_axis_address_arbiter.sv
// Directed bench for axis_address_arbiter with hand-computed expectations.
// Starvation expectations follow RASTERIX_ARBITER_AGING_EN.
module tb_axis_address_arbiter;
    localparam int NPRT = 4;
    localparam int AW   = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    axis_address_arbiter_if #(.NPRT(NPRT), .ADDR_WIDTH(AW)) bus ();

    axis_address_arbiter #(
        .NPRT      (NPRT),
        .ADDR_WIDTH(AW),
        .AGE_WIDTH (8),
        .AGE_LIMIT (4)
    ) dut (
        .aclk (clk),
        .reset(rst),
        .bus  (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic rnw,
                           input logic [AW-1:0] addr, input logic [AW-1:0] beats);
        bus.s_avalid[p]           = 1'b1;
        bus.s_arnw[p]             = rnw;
        bus.s_aaddr[p*AW +: AW]   = addr;
        bus.s_abeats[p*AW +: AW]  = beats;
    endtask

    task automatic clr_req(input int p);
        bus.s_avalid[p]          = 1'b0;
        bus.s_arnw[p]            = 1'b0;
        bus.s_aaddr[p*AW +: AW]  = '0;
        bus.s_abeats[p*AW +: AW] = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.m_aready = 1'b1;
        set_req(1, 1'b1, 32'h55, 32'd3);
        cyc();
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.s_aready !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_s_aready: got %b expected %b", bus.s_aready, 4'b0000);
        end
        n_cmp++;
        if (bus.m_avalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_m_avalid: got %b expected 0", bus.m_avalid);
        end
        n_cmp++;
        if ({bus.m_arnw, bus.m_aaddr, bus.m_abeats, bus.m_aport} !== '0) begin
            n_bad++;
            $display("FAIL reset_payload: got %h/%h/%h/%h expected all zero",
                     bus.m_arnw, bus.m_aaddr, bus.m_abeats, bus.m_aport);
        end
        n_cmp++;
        if (bus.zeroBeatError !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_zero_err: got %b expected 0", bus.zeroBeatError);
        end
        cyc();
        clr_req(1);
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_single();
        bus.m_aready = 1'b1;
        set_req(2, 1'b1, 32'h1000, 32'd16);
        @(negedge clk);
        n_cmp++;
        if (bus.s_aready !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_grant: got %b expected %b", bus.s_aready, 4'b0100);
        end
        cyc();
        clr_req(2);
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b1 || bus.m_aport !== 2'd2) begin
            n_bad++;
            $display("FAIL single_issue: got valid %b port %0d expected 1 port 2",
                     bus.m_avalid, bus.m_aport);
        end
        n_cmp++;
        if (bus.m_aaddr !== 32'h1000 || bus.m_abeats !== 32'd16 || bus.m_arnw !== 1'b1) begin
            n_bad++;
            $display("FAIL single_payload: got %h/%0d/%b expected 1000/16/1",
                     bus.m_aaddr, bus.m_abeats, bus.m_arnw);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b0 || bus.s_aready !== 4'b0000) begin
            n_bad++;
            $display("FAIL single_done: got valid %b ready %b expected 0 0000",
                     bus.m_avalid, bus.s_aready);
        end
        cyc();
    endtask

    task automatic test_contention();
        bus.m_aready = 1'b1;
        set_req(0, 1'b0, 32'hA0, 32'd1);
        set_req(3, 1'b1, 32'hA3, 32'd2);
        @(negedge clk);
        n_cmp++;
        if (bus.s_aready !== 4'b0001) begin
            n_bad++;
            $display("FAIL cont_first: got %b expected %b", bus.s_aready, 4'b0001);
        end
        cyc();
        clr_req(0);
        @(negedge clk);
        n_cmp++;
        if (bus.m_aport !== 2'd0 || bus.m_aaddr !== 32'hA0 || bus.s_aready !== 4'b0000) begin
            n_bad++;
            $display("FAIL cont_issue0: got port %0d addr %h ready %b expected 0 a0 0000",
                     bus.m_aport, bus.m_aaddr, bus.s_aready);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.s_aready !== 4'b1000) begin
            n_bad++;
            $display("FAIL cont_second: got %b expected %b", bus.s_aready, 4'b1000);
        end
        cyc();
        clr_req(3);
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b1 || bus.m_aport !== 2'd3 || bus.m_aaddr !== 32'hA3
            || bus.m_abeats !== 32'd2 || bus.m_arnw !== 1'b1) begin
            n_bad++;
            $display("FAIL cont_issue3: got v%b port %0d addr %h beats %0d expected v1 3 a3 2",
                     bus.m_avalid, bus.m_aport, bus.m_aaddr, bus.m_abeats);
        end
        cyc();
        cyc();
    endtask

    task automatic test_backpressure();
        bus.m_aready = 1'b0;
        set_req(1, 1'b0, 32'h2222, 32'd5);
        @(negedge clk);
        n_cmp++;
        if (bus.s_aready !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_grant: got %b expected %b", bus.s_aready, 4'b0010);
        end
        cyc();
        clr_req(1);
        set_req(0, 1'b1, 32'h3333, 32'd3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.m_avalid !== 1'b1 || bus.m_aaddr !== 32'h2222 || bus.m_abeats !== 32'd5
                || bus.m_aport !== 2'd1 || bus.s_aready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_hold%0d: got v%b addr %h beats %0d port %0d ready %b",
                         k, bus.m_avalid, bus.m_aaddr, bus.m_abeats, bus.m_aport, bus.s_aready);
            end
            cyc();
        end
        bus.m_aready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b1 || bus.s_aready !== 4'b0000) begin
            n_bad++;
            $display("FAIL bp_release: got v%b ready %b expected 1 0000",
                     bus.m_avalid, bus.s_aready);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.s_aready !== 4'b0001) begin
            n_bad++;
            $display("FAIL bp_next: got %b expected %b", bus.s_aready, 4'b0001);
        end
        cyc();
        clr_req(0);
        @(negedge clk);
        n_cmp++;
        if (bus.m_aport !== 2'd0 || bus.m_aaddr !== 32'h3333) begin
            n_bad++;
            $display("FAIL bp_issue0: got port %0d addr %h expected 0 3333",
                     bus.m_aport, bus.m_aaddr);
        end
        cyc();
        cyc();
    endtask

    task automatic test_starvation();
        logic [3:0] exp_tab [9];
        logic [3:0] exp_v;
`ifdef RASTERIX_ARBITER_AGING_EN
        exp_tab = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010,
                    4'b0000, 4'b0001, 4'b0000, 4'b0001};
`else
        exp_tab = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001,
                    4'b0000, 4'b0001, 4'b0000, 4'b0001};
`endif
        bus.m_aready = 1'b1;
        set_req(0, 1'b0, 32'h40, 32'd1);
        set_req(1, 1'b1, 32'h41, 32'd1);
        for (int k = 0; k < 9; k++) begin
            exp_v = exp_tab[k];
            @(negedge clk);
            n_cmp++;
            if (bus.s_aready !== exp_v) begin
                n_bad++;
                $display("FAIL starve_c%0d: got %b expected %b", k, bus.s_aready, exp_v);
            end
            if (bus.s_aready[1]) begin
                cyc();
                clr_req(1);
            end else begin
                cyc();
            end
        end
        clr_req(0);
        clr_req(1);
        cyc();
        cyc();
        cyc();
    endtask

    task automatic test_zero_beats();
        bus.m_aready = 1'b1;
        set_req(1, 1'b0, 32'h77, 32'd0);
        @(negedge clk);
        n_cmp++;
        if (bus.s_aready !== 4'b0010) begin
            n_bad++;
            $display("FAIL zero_grant: got %b expected %b", bus.s_aready, 4'b0010);
        end
        cyc();
        clr_req(1);
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b0 || bus.zeroBeatError !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_flag: got v%b err %b expected 0 1",
                     bus.m_avalid, bus.zeroBeatError);
        end
        cyc();
        cyc();
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b0 || bus.zeroBeatError !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_sticky: got v%b err %b expected 0 1",
                     bus.m_avalid, bus.zeroBeatError);
        end
        cyc();
    endtask

    task automatic test_reset_in_issue();
        bus.m_aready = 1'b0;
        set_req(3, 1'b1, 32'hABCD, 32'd7);
        cyc();
        clr_req(3);
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b1 || bus.m_aaddr !== 32'hABCD) begin
            n_bad++;
            $display("FAIL rst_pre: got v%b addr %h expected 1 abcd",
                     bus.m_avalid, bus.m_aaddr);
        end
        cyc();
        rst = 1'b1;
        cyc();
        @(negedge clk);
        n_cmp++;
        if (bus.m_avalid !== 1'b0 || bus.s_aready !== 4'b0000 || bus.zeroBeatError !== 1'b0
            || bus.m_aaddr !== 32'h0 || bus.m_abeats !== 32'h0 || bus.m_aport !== 2'd0
            || bus.m_arnw !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_issue: got v%b r%b err%b addr %h beats %h port %0d rnw %b",
                     bus.m_avalid, bus.s_aready, bus.zeroBeatError,
                     bus.m_aaddr, bus.m_abeats, bus.m_aport, bus.m_arnw);
        end
        cyc();
        rst = 1'b0;
        bus.m_aready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.m_avalid !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_noreplay%0d: got v%b expected 0", k, bus.m_avalid);
            end
            cyc();
        end
    endtask

    initial begin
        bus.s_avalid = '0;
        bus.s_arnw   = '0;
        bus.s_aaddr  = '0;
        bus.s_abeats = '0;
        bus.m_aready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_starvation();
        test_zero_beats();
        test_reset_in_issue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
